hmc_port_arbiter: RTL

- Shares the single HMC command/write-data FIFO interface (cmd_data_interface write side) among NUM_REQ processing engines, e.g. several image-kernel engines.
- Round-robin arbitrates command requests and builds the HMC tag from the requester ID plus the requester's local tag.
- Throttles reads per requester by outstanding-tag count and routes read responses back by tag.
- Sits between the engines and the FIFO wrapper; runs entirely on rx_clk.

---
 rtl/hmc_port_arbiter_if.sv | 49 ++++
 rtl/hmc_port_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/hmc_port_arbiter_if.sv
// hmc_port_arbiter_if: engine requests, HMC command/write-data FIFO write side and read responses.
// slave is the arbiter's view; master is the engines/FIFO-wrapper view.
interface hmc_port_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int TAG_WIDTH  = 6,
    parameter int ADDR_WIDTH = 34,
    parameter int SIZE_WIDTH = 4,
    parameter int DATA_WIDTH = 128
);
    localparam int LTAG_WIDTH = TAG_WIDTH - ID_WIDTH;
    logic [NUM_REQ-1:0]                  req_valid;
    logic [NUM_REQ-1:0]                  req_ready;
    logic [4*NUM_REQ-1:0]                req_cmd;
    logic [ADDR_WIDTH*NUM_REQ-1:0]       req_addr;
    logic [SIZE_WIDTH*NUM_REQ-1:0]       req_size;
    logic [LTAG_WIDTH*NUM_REQ-1:0]       req_ltag;
    logic [DATA_WIDTH*NUM_REQ-1:0]       req_wdata;
    logic                                cmd_full;
    logic                                data_full;
    logic                                wr_en_cmd;
    logic                                wr_en_data;
    logic [3:0]                          cmd_out;
    logic [ADDR_WIDTH-1:0]               addr_out;
    logic [SIZE_WIDTH-1:0]               size_out;
    logic [TAG_WIDTH-1:0]                tag_out;
    logic [DATA_WIDTH-1:0]               data_out;
    logic [DATA_WIDTH-1:0]               rd_data;
    logic [TAG_WIDTH-1:0]                rd_data_tag;
    logic                                rd_data_valid;
    logic [NUM_REQ-1:0]                  rsp_valid;
    logic [DATA_WIDTH-1:0]               rsp_data;
    logic [LTAG_WIDTH-1:0]               rsp_ltag;
    logic [(LTAG_WIDTH+1)*NUM_REQ-1:0]   outstanding;
    logic                                idle;
    logic                                err_tag;
    modport slave (
        input  req_valid, req_cmd, req_addr, req_size, req_ltag, req_wdata,
               cmd_full, data_full, rd_data, rd_data_tag, rd_data_valid,
        output req_ready, wr_en_cmd, wr_en_data, cmd_out, addr_out, size_out, tag_out,
               data_out, rsp_valid, rsp_data, rsp_ltag, outstanding, idle, err_tag
    );
    modport master (
        output req_valid, req_cmd, req_addr, req_size, req_ltag, req_wdata,
               cmd_full, data_full, rd_data, rd_data_tag, rd_data_valid,
        input  req_ready, wr_en_cmd, wr_en_data, cmd_out, addr_out, size_out, tag_out,
               data_out, rsp_valid, rsp_data, rsp_ltag, outstanding, idle, err_tag
    );
endinterface

// File: rtl/hmc_port_arbiter.sv
// hmc_port_arbiter: round-robin sharing of the HMC command/write-data FIFOs among NUM_REQ engines,
// with per-engine outstanding-read throttling and tag-based read-response routing.
module hmc_port_arbiter #(
    parameter int         NUM_REQ    = 4,
    parameter int         ID_WIDTH   = 2,
    parameter int         TAG_WIDTH  = 6,
    parameter int         ADDR_WIDTH = 34,
    parameter int         SIZE_WIDTH = 4,
    parameter int         DATA_WIDTH = 128,
    parameter int         MAX_OUT    = 16,
    parameter logic [3:0] HMC_CMD_RD = 4'b0110
) (
    input logic                rx_clk,
    input logic                rst,
    hmc_port_arbiter_if.slave  bus
);
    localparam int                  LTAG_WIDTH = TAG_WIDTH - ID_WIDTH;
    localparam int                  CW         = LTAG_WIDTH + 1;
    localparam logic [CW-1:0]       MAX_C      = CW'(MAX_OUT);
    localparam logic [ID_WIDTH:0]   NREQ_C     = (ID_WIDTH+1)'(NUM_REQ);
    localparam logic [ID_WIDTH-1:0] LAST_ID    = ID_WIDTH'(NUM_REQ-1);

    logic [ID_WIDTH-1:0]             ptr_q, ptr_d, gnt_id, hi_id, lo_id, rsp_id;
    logic                            gnt_v, hi_v, lo_v, gnt_rd, rsp_ok;
    logic [NUM_REQ-1:0]              elig, inc, dec, under;
    logic [NUM_REQ-1:0][CW-1:0]      cnt_q, cnt_d;
    logic                            wr_en_cmd_q, wr_en_data_q, idle_q, err_q;
    logic [3:0]                      cmd_q;
    logic [ADDR_WIDTH-1:0]           addr_q;
    logic [SIZE_WIDTH-1:0]           size_q;
    logic [TAG_WIDTH-1:0]            tag_q;
    logic [DATA_WIDTH-1:0]           data_q, rsp_data_q;
    logic [NUM_REQ-1:0]              rsp_valid_q;
    logic [LTAG_WIDTH-1:0]           rsp_ltag_q;

    assign rsp_id = bus.rd_data_tag[TAG_WIDTH-1 -: ID_WIDTH];
    assign rsp_ok = bus.rd_data_valid && ({1'b0, rsp_id} < NREQ_C);

    // Reads are throttled by outstanding count; everything else carries write data.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign elig[i]  = !rst && bus.req_valid[i] && !bus.cmd_full &&
                          ((bus.req_cmd[4*i +: 4] == HMC_CMD_RD) ? (cnt_q[i] < MAX_C) : !bus.data_full);
        assign inc[i]   = gnt_v && gnt_rd && (gnt_id == ID_WIDTH'(i));
        assign dec[i]   = rsp_ok && (rsp_id == ID_WIDTH'(i));
        assign under[i] = dec[i] && !inc[i] && (cnt_q[i] == '0);
        assign cnt_d[i] = (inc[i] && !dec[i]) ? cnt_q[i] + 1'b1 :
                          (dec[i] && !inc[i] && cnt_q[i] != '0) ? cnt_q[i] - 1'b1 : cnt_q[i];
    end

    // Lowest eligible at or above the pointer wins, else lowest eligible overall (wrap).
    always_comb begin
        hi_v  = 1'b0;
        lo_v  = 1'b0;
        hi_id = '0;
        lo_id = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (elig[j]) begin
                lo_v  = 1'b1;
                lo_id = ID_WIDTH'(j);
                if (j >= int'(ptr_q)) begin
                    hi_v  = 1'b1;
                    hi_id = ID_WIDTH'(j);
                end
            end
        end
    end

    assign gnt_v         = lo_v;
    assign gnt_id        = hi_v ? hi_id : lo_id;
    assign gnt_rd        = bus.req_cmd[4*gnt_id +: 4] == HMC_CMD_RD;
    assign ptr_d         = gnt_v ? ((gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1) : ptr_q;
    assign bus.req_ready = gnt_v ? NUM_REQ'(1) << gnt_id : '0;

    always_ff @(posedge rx_clk) begin
        if (rst) begin
            ptr_q        <= '0;
            cnt_q        <= '0;
            wr_en_cmd_q  <= 1'b0;
            wr_en_data_q <= 1'b0;
            cmd_q        <= '0;
            addr_q       <= '0;
            size_q       <= '0;
            tag_q        <= '0;
            data_q       <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            rsp_ltag_q   <= '0;
            err_q        <= 1'b0;
            idle_q       <= 1'b1;
        end else begin
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            wr_en_cmd_q  <= gnt_v;
            wr_en_data_q <= gnt_v && !gnt_rd;
            if (gnt_v) begin
                cmd_q  <= bus.req_cmd[4*gnt_id +: 4];
                addr_q <= bus.req_addr[ADDR_WIDTH*gnt_id +: ADDR_WIDTH];
                size_q <= bus.req_size[SIZE_WIDTH*gnt_id +: SIZE_WIDTH];
                tag_q  <= {gnt_id, bus.req_ltag[LTAG_WIDTH*gnt_id +: LTAG_WIDTH]};
            end
            if (gnt_v && !gnt_rd)
                data_q <= bus.req_wdata[DATA_WIDTH*gnt_id +: DATA_WIDTH];
            rsp_valid_q <= rsp_ok ? NUM_REQ'(1) << rsp_id : '0;
            if (rsp_ok) begin
                rsp_data_q <= bus.rd_data;
                rsp_ltag_q <= bus.rd_data_tag[LTAG_WIDTH-1:0];
            end
            err_q  <= err_q || (bus.rd_data_valid && !rsp_ok) || (|under);
            idle_q <= (cnt_d == '0) && !gnt_v;
        end
    end

    assign bus.wr_en_cmd   = wr_en_cmd_q;
    assign bus.wr_en_data  = wr_en_data_q;
    assign bus.cmd_out     = cmd_q;
    assign bus.addr_out    = addr_q;
    assign bus.size_out    = size_q;
    assign bus.tag_out     = tag_q;
    assign bus.data_out    = data_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_ltag    = rsp_ltag_q;
    assign bus.outstanding = cnt_q;
    assign bus.idle        = idle_q;
    assign bus.err_tag     = err_q;
endmodule
